tcu_exec_unit: RTL and testbench
================================

# tcu_exec_unit

- Multi-cycle execution unit on the responder side of the TCU interface that `microcode_sequencer` drives.
- Accepts one operation at a time on a level-sensitive enable handshake.
- Computes a 36-bit two's-complement result with a fixed, opcode-dependent latency, including an iterative radix-2 divider.
- Holds result/valid until the sequencer withdraws enable.
- Replaces the behavioural TCU stand-in in system-level simulation and is the synthesizable compute back end for microcode routines.

## Interface
Parameters:
- DATA_WIDTH, 36, operand/result width
- FAST_LATENCY, 3, accept-to-valid cycles for ADD/SUB/ABS/NEG/CMP/illegal/div-by-zero (min 2)
- MUL_LATENCY, 4, accept-to-valid cycles for MUL/MAC (min 2)

Ports:
- clk  in  1  system clock; single clock domain, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- tcu_enable  in  1  request; level, held by sequencer until valid seen.
- tcu_operation  in  4  opcode, sampled at accept.
- tcu_operand_a / tcu_operand_b / tcu_operand_c  in  36 each  operands, sampled at accept.
- tcu_result  out  36  result, stable while tcu_valid=1.
- tcu_valid  out  1  result available.
- tcu_ready  out  1  idle, can accept.
- tcu_error  out  1  qualifies tcu_valid; operation faulted.
- state  out  2  debug: 0 IDLE, 1 EXEC, 2 DIV, 3 DONE.
- op_count  out  32  completed operations (errors included), wraps.

## Operation
- Opcodes (two's complement, wrap modulo 2^36, no overflow error):
  - 0 ADD a+b; 1 SUB a-b; 2 MUL low 36 bits of a*b.
  - 3 DIV a/b truncated toward zero; 4 ABS |a| (most negative value returns itself).
  - 5 MOD remainder, sign follows dividend; 6 NEG -a; 7 CMP returns -1/0/+1 for a<b / a==b / a>b signed.
  - 8 MAC low 36 bits of a*b+c; 9-15 illegal.
- Errors: illegal opcode, or DIV/MOD with b==0 -> result 0, tcu_error=1, FAST_LATENCY.
- States:
  - IDLE: ready=1. tcu_enable=1 at a clock edge is an accept: latch opcode/operands, ready<=0, clear error.
    - DIV/MOD with b!=0 -> DIV; all others -> EXEC.
  - EXEC: down-counter loaded with latency-1; result computed from latched operands; counter reaches 0 -> DONE.
  - DIV: one setup cycle (magnitudes of a, b) -> DATA_WIDTH restoring-shift iterations, one quotient bit per cycle -> one sign-fixup cycle -> DONE.
  - DONE: valid=1, result/error held, op_count incremented on entry. Leave to IDLE on first edge with tcu_enable=0; valid, error clear at that edge.
- Operands are latched: input changes after accept have no effect.
- tcu_enable dropped mid-operation: operation still completes. DONE then lasts exactly one cycle (valid pulse).
- No accept from DONE. Enable held high after valid produces no new operation until enable goes low for at least one edge.

## Timing
- Reset values (asynchronous, immediate):
  - result=0, valid=0, error=0, ready=1, state=IDLE, op_count=0.
  - Any in-flight operation is discarded.
- Accept at edge N:
  - ready=0 after edge N.
  - valid=1 after edge N+L, with L = FAST_LATENCY, MUL_LATENCY, or DATA_WIDTH+2 (38) for non-zero DIV/MOD.
- ready returns to 1 on the same edge valid clears.
- Minimum spacing between accepts is L+2 cycles (L cycles busy, one cycle in DONE with enable low, then accept on the next edge).
- tcu_result is registered, with no combinational path from inputs to outputs.

## Test plan
- Reset asserted mid-DIV (cycle 10) -> all outputs at reset values the same cycle; after release, ADD 0x14+0x4 -> result 0x18, valid at N+3, op_count=1.
- DIV 100/10 -> 0x00000000A at N+38. MOD 100%10 -> 0. DIV -7/2 -> 0xFFFFFFFFD. MOD -7%2 -> 0xFFFFFFFFF.
- DIV 0x64/0 -> error=1, result 0 at N+3. Opcode 0xC -> error=1, result 0 at N+3. Next ADD clears error.
- MUL 0x100000000*0x10 -> 0 (wrap) at N+4. MAC 3*4+5 -> 0x11.
  - CMP 5 vs -1 -> 1; CMP 2 vs 2 -> 0.
  - ABS 0x800000000 -> 0x800000000, no error.
- Operands changed and enable held high after accept -> result unaffected; valid stays high until enable drops; no second accept while enable is high.
- Enable dropped one cycle after accept of SUB 5-7 -> valid pulses one cycle with 0xFFFFFFFFE; ready=1 the next cycle.

Source files
------------

// File: rtl/tcu_exec_unit.sv
// Multi-cycle TCU execution unit: level enable handshake, fixed per-opcode latency,
// restoring radix-2 divider, result/valid held until the sequencer drops enable.
module tcu_exec_unit #(
  parameter int DATA_WIDTH   = 36,
  parameter int FAST_LATENCY = 3,
  parameter int MUL_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tcu_enable,
  input  logic [3:0]            tcu_operation,
  input  logic [DATA_WIDTH-1:0] tcu_operand_a,
  input  logic [DATA_WIDTH-1:0] tcu_operand_b,
  input  logic [DATA_WIDTH-1:0] tcu_operand_c,
  output logic [DATA_WIDTH-1:0] tcu_result,
  output logic                  tcu_valid,
  output logic                  tcu_ready,
  output logic                  tcu_error,
  output logic [1:0]            state,
  output logic [31:0]           op_count
);

  // state | meaning
  // IDLE  | ready, waiting for tcu_enable
  // EXEC  | fixed-latency op (or fault) counting down
  // DIV   | setup, DATA_WIDTH restoring steps, sign fixup
  // DONE  | valid held until tcu_enable drops
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_ABS = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_MAC = 4'd8;

  localparam int CW = $clog2(DATA_WIDTH + 2) + 1;
  localparam logic [CW-1:0] DIV_SETUP = CW'(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, op_c_q;
  logic                  fault_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  error_q;
  logic [31:0]           op_count_q;

  logic                  accept;
  logic                  in_divmod, in_illegal, in_fault, in_to_div;
  logic [CW-1:0]         in_cnt;
  logic                  cnt_zero;
  logic [DATA_WIDTH-1:0] fast_res;
  logic [DATA_WIDTH:0]   div_shift;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_rem_next;
  logic [DATA_WIDTH-1:0] div_quot, div_rem;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? -v : v;
  endfunction

  // Accept decode looks at the live inputs; everything it feeds is registered.
  always_comb begin
    accept     = (state_q == S_IDLE) && tcu_enable;
    in_divmod  = (tcu_operation == OP_DIV) || (tcu_operation == OP_MOD);
    in_illegal = (tcu_operation > OP_MAC);
    in_fault   = in_illegal || (in_divmod && (tcu_operand_b == '0));
    in_to_div  = in_divmod && (tcu_operand_b != '0);
    if (in_to_div)
      in_cnt = DIV_SETUP;
    else if ((tcu_operation == OP_MUL) || (tcu_operation == OP_MAC))
      in_cnt = CW'(MUL_LATENCY - 1);
    else
      in_cnt = CW'(FAST_LATENCY - 1);
    cnt_zero = (cnt_q == '0);
  end

  always_comb begin
    fast_res = '0;
    case (op_q)
      OP_ADD: fast_res = op_a_q + op_b_q;
      OP_SUB: fast_res = op_a_q - op_b_q;
      OP_MUL: fast_res = op_a_q * op_b_q;
      OP_ABS: fast_res = mag(op_a_q);
      OP_NEG: fast_res = -op_a_q;
      OP_CMP: begin
        if ($signed(op_a_q) < $signed(op_b_q))
          fast_res = '1;
        else if (op_a_q == op_b_q)
          fast_res = '0;
        else
          fast_res = DATA_WIDTH'(1);
      end
      OP_MAC: fast_res = op_a_q * op_b_q + op_c_q;
      default: fast_res = '0;
    endcase
  end

  // One restoring step: the quotient bit shifts into dvd_q as the dividend shifts out.
  always_comb begin
    div_shift    = {rem_q, dvd_q[DATA_WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, dvs_q});
    div_rem_next = div_ge ? DATA_WIDTH'(div_shift - {1'b0, dvs_q})
                          : div_shift[DATA_WIDTH-1:0];
    div_quot     = (op_a_q[DATA_WIDTH-1] ^ op_b_q[DATA_WIDTH-1]) ? -dvd_q : dvd_q;
    div_rem      = op_a_q[DATA_WIDTH-1] ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (tcu_enable) state_d = in_to_div ? S_DIV : S_EXEC;
      S_EXEC: if (cnt_zero) state_d = S_DONE;
      S_DIV:  if (cnt_zero) state_d = S_DONE;
      S_DONE: if (!tcu_enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tcu_ready = (state_q == S_IDLE);
    tcu_valid = (state_q == S_DONE);
    state     = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= tcu_operation;
            op_a_q  <= tcu_operand_a;
            op_b_q  <= tcu_operand_b;
            op_c_q  <= tcu_operand_c;
            fault_q <= in_fault;
            cnt_q   <= in_cnt;
            error_q <= 1'b0;
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
            result_q   <= fault_q ? '0 : fast_res;
            error_q    <= fault_q;
            op_count_q <= op_count_q + 32'd1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          if (cnt_q == DIV_SETUP) begin
            dvd_q <= mag(op_a_q);
            dvs_q <= mag(op_b_q);
            rem_q <= '0;
            cnt_q <= cnt_q - CW'(1);
          end else if (!cnt_zero) begin
            rem_q <= div_rem_next;
            dvd_q <= {dvd_q[DATA_WIDTH-2:0], div_ge};
            cnt_q <= cnt_q - CW'(1);
          end else begin
            result_q   <= (op_q == OP_MOD) ? div_rem : div_quot;
            error_q    <= 1'b0;
            op_count_q <= op_count_q + 32'd1;
          end
        end
        S_DONE: begin
          if (!tcu_enable) error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tcu_result = result_q;
  assign tcu_error  = error_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_tcu_exec_unit.sv
// Self-checking bench for tcu_exec_unit: directed scenarios plus randomized ops
// compared against a signed-arithmetic reference model.
module tb_tcu_exec_unit;

  localparam int W    = 36;
  localparam int FAST = 3;
  localparam int MULL = 4;
  localparam int DIVL = W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tcu_enable;
  logic [3:0]    tcu_operation;
  logic [W-1:0]  tcu_operand_a, tcu_operand_b, tcu_operand_c;
  logic [W-1:0]  tcu_result;
  logic          tcu_valid, tcu_ready, tcu_error;
  logic [1:0]    state;
  logic [31:0]   op_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  tcu_exec_unit #(.DATA_WIDTH(W), .FAST_LATENCY(FAST), .MUL_LATENCY(MULL)) dut (
    .clk(clk), .rst_n(rst_n), .tcu_enable(tcu_enable), .tcu_operation(tcu_operation),
    .tcu_operand_a(tcu_operand_a), .tcu_operand_b(tcu_operand_b), .tcu_operand_c(tcu_operand_c),
    .tcu_result(tcu_result), .tcu_valid(tcu_valid), .tcu_ready(tcu_ready),
    .tcu_error(tcu_error), .state(state), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference: sign-extend to 64 bits, use native signed arithmetic, keep the low 36 bits.
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, b, c,
                                    output logic [W-1:0] r, output logic err, output int lat);
    longint sa, sb, sc, x;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    x = 0; err = 1'b0; lat = FAST;
    case (op)
      4'd0: x = sa + sb;
      4'd1: x = sa - sb;
      4'd2: begin x = sa * sb; lat = MULL; end
      4'd3: if (sb == 0) err = 1'b1; else begin x = sa / sb; lat = DIVL; end
      4'd4: x = (sa < 0) ? -sa : sa;
      4'd5: if (sb == 0) err = 1'b1; else begin x = sa % sb; lat = DIVL; end
      4'd6: x = -sa;
      4'd7: x = (sa < sb) ? -1 : ((sa == sb) ? 0 : 1);
      4'd8: begin x = sa * sb + sc; lat = MULL; end
      default: err = 1'b1;
    endcase
    r = err ? '0 : x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand36();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return W'($urandom_range(0, 40));
      1: return -W'($urandom_range(0, 40));
      2: return '0;
      3: return ($urandom_range(0, 1) != 0) ? 36'h800000000 : 36'h7FFFFFFFF;
      default: return v[W-1:0];
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, b, c,
                       input int hold, input bit scramble);
    logic [W-1:0] er;
    logic ee;
    int lat, cyc;
    ref_model(op, a, b, c, er, ee, lat);
    @(negedge clk);
    vectors++;
    if (tcu_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_before_accept op=%0d got=%b want=1", op, tcu_ready);
    end
    tcu_enable = 1'b1; tcu_operation = op;
    tcu_operand_a = a; tcu_operand_b = b; tcu_operand_c = c;
    @(posedge clk);
    #1;
    if (scramble) begin
      tcu_operation = 4'($urandom); tcu_operand_a = rand36();
      tcu_operand_b = rand36(); tcu_operand_c = rand36();
    end
    @(negedge clk);
    vectors++;
    if (tcu_ready !== 1'b0 || tcu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_accept op=%0d ready=%b valid=%b want ready=0 valid=0", op, tcu_ready, tcu_valid);
    end
    cyc = 0;
    while (tcu_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    exp_count++;
    vectors++;
    if (cyc != lat) begin
      miscompares++; $display("FAIL latency op=%0d got=%0d want=%0d", op, cyc, lat);
    end
    vectors++;
    if (tcu_result !== er) begin
      miscompares++;
      $display("FAIL result op=%0d a=%h b=%h c=%h got=%h want=%h", op, a, b, c, tcu_result, er);
    end
    vectors++;
    if (tcu_error !== ee) begin
      miscompares++; $display("FAIL error op=%0d got=%b want=%b", op, tcu_error, ee);
    end
    vectors++;
    if (op_count !== 32'(exp_count)) begin
      miscompares++; $display("FAIL op_count op=%0d got=%0d want=%0d", op, op_count, exp_count);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (scramble) tcu_operand_a = rand36();
      vectors++;
      if (tcu_valid !== 1'b1 || tcu_ready !== 1'b0 || tcu_result !== er ||
          op_count !== 32'(exp_count)) begin
        miscompares++;
        $display("FAIL hold op=%0d valid=%b ready=%b result=%h count=%0d want 1 0 %h %0d",
                 op, tcu_valid, tcu_ready, tcu_result, op_count, er, exp_count);
      end
    end
    tcu_enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (tcu_valid !== 1'b0 || tcu_error !== 1'b0 || tcu_ready !== 1'b1 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL release op=%0d valid=%b error=%b ready=%b state=%0d want 0 0 1 0",
               op, tcu_valid, tcu_error, tcu_ready, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tcu_enable = 1'b0; tcu_operation = '0;
    tcu_operand_a = '0; tcu_operand_b = '0; tcu_operand_c = '0;
    exp_count = 0;
    #12;
    vectors++;
    if (tcu_result !== '0 || tcu_valid !== 1'b0 || tcu_error !== 1'b0 ||
        tcu_ready !== 1'b1 || state !== 2'd0 || op_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_values result=%h valid=%b error=%b ready=%b state=%0d count=%0d",
               tcu_result, tcu_valid, tcu_error, tcu_ready, state, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_div();
    do_op(4'd0, 36'd1, 36'd2, 36'd0, 0, 1'b0);
    @(negedge clk);
    tcu_enable = 1'b1; tcu_operation = 4'd3;
    tcu_operand_a = 36'd100; tcu_operand_b = 36'd10;
    @(posedge clk);
    repeat (10) @(negedge clk);
    vectors++;
    if (state !== 2'd2) begin
      miscompares++; $display("FAIL div_state got=%0d want=2", state);
    end
    #2;
    rst_n = 1'b0;
    tcu_enable = 1'b0;
    exp_count = 0;
    #1;
    vectors++;
    if (tcu_result !== '0 || tcu_valid !== 1'b0 || tcu_error !== 1'b0 ||
        tcu_ready !== 1'b1 || state !== 2'd0 || op_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_div result=%h valid=%b error=%b ready=%b state=%0d count=%0d",
               tcu_result, tcu_valid, tcu_error, tcu_ready, state, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd0, 36'h14, 36'h4, 36'd0, 0, 1'b0);
  endtask

  task automatic test_divide();
    do_op(4'd3, 36'd100, 36'd10, 36'd0, 0, 1'b0);
    do_op(4'd5, 36'd100, 36'd10, 36'd0, 0, 1'b0);
    do_op(4'd3, -36'd7, 36'd2, 36'd0, 0, 1'b0);
    do_op(4'd5, -36'd7, 36'd2, 36'd0, 0, 1'b0);
    do_op(4'd3, 36'h800000000, -36'd1, 36'd0, 0, 1'b0);
    do_op(4'd5, 36'd7, -36'd3, 36'd0, 0, 1'b0);
  endtask

  task automatic test_errors();
    do_op(4'd3, 36'h64, 36'd0, 36'd0, 0, 1'b0);
    do_op(4'hC, 36'd5, 36'd6, 36'd7, 0, 1'b0);
    do_op(4'd5, 36'd9, 36'd0, 36'd0, 1, 1'b0);
    do_op(4'd0, 36'd3, 36'd4, 36'd0, 0, 1'b0);
  endtask

  task automatic test_arith();
    do_op(4'd2, 36'h100000000, 36'h10, 36'd0, 0, 1'b0);
    do_op(4'd8, 36'd3, 36'd4, 36'd5, 0, 1'b0);
    do_op(4'd7, 36'd5, -36'd1, 36'd0, 0, 1'b0);
    do_op(4'd7, 36'd2, 36'd2, 36'd0, 0, 1'b0);
    do_op(4'd7, -36'd3, 36'd2, 36'd0, 0, 1'b0);
    do_op(4'd4, 36'h800000000, 36'd0, 36'd0, 0, 1'b0);
    do_op(4'd6, 36'd1, 36'd0, 36'd0, 0, 1'b0);
  endtask

  task automatic test_hold_scramble();
    do_op(4'd1, 36'd50, 36'd8, 36'd0, 6, 1'b1);
    do_op(4'd5, -36'd100, 36'd7, 36'd0, 4, 1'b1);
    do_op(4'd8, 36'd11, -36'd2, 36'd9, 3, 1'b1);
  endtask

  task automatic test_drop_early();
    int cyc;
    @(negedge clk);
    tcu_enable = 1'b1; tcu_operation = 4'd1;
    tcu_operand_a = 36'd5; tcu_operand_b = 36'd7; tcu_operand_c = '0;
    @(posedge clk);
    @(negedge clk);
    tcu_enable = 1'b0;
    cyc = 0;
    while (tcu_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    exp_count++;
    vectors++;
    if (cyc != FAST || tcu_result !== 36'hFFFFFFFFE) begin
      miscompares++;
      $display("FAIL drop_early_result lat=%0d result=%h want %0d FFFFFFFFE", cyc, tcu_result, FAST);
    end
    @(negedge clk);
    vectors++;
    if (tcu_valid !== 1'b0 || tcu_ready !== 1'b1 || op_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL drop_early_pulse valid=%b ready=%b count=%0d want 0 1 %0d",
               tcu_valid, tcu_ready, op_count, exp_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      a = rand36();
      b = rand36();
      do_op(op, a, b, rand36(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_div();
    test_divide();
    test_errors();
    test_arith();
    test_hold_scramble();
    test_drop_early();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
